// File: rtl/biquad8_coeff_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : biquad8_coeff_loader_if
// Brief    : WISHBONE initiator/target bundle between the coefficient loader
//            and the biquad8 control port.
// Revision : 1.0 - initial release
// ============================================================================
interface biquad8_coeff_loader_if;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [6:0]  wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic [31:0] wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
    );
endinterface
`default_nettype wire

// File: rtl/biquad8_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module   : biquad8_coeff_loader
// Brief    : Drains a FIFO of coefficient writes onto WISHBONE, then writes the
//            update strobe. Define BIQUAD8_LOADER_TIMEOUT_EN for response timeout.
// Revision : 1.0 - initial release
// ============================================================================
module biquad8_coeff_loader #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 255
) (
    input  wire         wb_clk_i,
    input  wire         wb_rst_ni,
    input  wire         cmd_valid_i,
    output logic        cmd_ready_o,
    input  wire  [6:0]  cmd_adr_i,
    input  wire  [17:0] cmd_dat_i,
    input  wire         cmd_last_i,
    input  wire         clr_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    biquad8_coeff_loader_if.master wb
);

    localparam int             c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_AW:0]  c_FULL = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_UPD  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [23:0]   r_mem [FIFO_DEPTH];
    logic [c_AW:0] r_wr_ptr, r_rd_ptr, w_wr_nxt, w_rd_nxt, w_count, w_count_nxt;
    logic [23:0]   w_head;
    logic          r_upd_pend, w_upd_pend_nxt;
    logic          w_push, w_pop, w_active, w_err, w_rty, w_ack, w_consumed;
    logic          w_timeout;
    logic          w_unused;

    // Entry layout: {last, adr[6:2], dat[17:0]}
    assign w_head     = r_mem[r_rd_ptr[c_AW-1:0]];
    assign w_push     = cmd_valid_i && cmd_ready_o;
    assign w_active   = wb.wb_cyc_o && wb.wb_stb_o;
    assign w_err      = w_active && wb.wb_err_i;
    assign w_rty      = w_active && !wb.wb_err_i && wb.wb_rty_i;
    assign w_ack      = w_active && !wb.wb_err_i && !wb.wb_rty_i && wb.wb_ack_i;
    assign w_consumed = w_err || w_ack;
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_unused   = (^{wb.wb_dat_i, cmd_adr_i[1:0]}) ^ (TIMEOUT == 0);

`ifdef BIQUAD8_LOADER_TIMEOUT_EN
    localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] r_tmo_cnt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_tmo_cnt <= '0;
        end else if (!w_active) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
        end
    end

    assign w_timeout = w_active && !wb.wb_ack_i && !wb.wb_err_i && !wb.wb_rty_i &&
                       (r_tmo_cnt == c_TMO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_pop          = 1'b0;
        w_upd_pend_nxt = r_upd_pend;
        case (r_state)
            S_IDLE: if (w_count != '0) w_state_nxt = S_WR;
            S_WR: begin
                if (w_timeout) begin
                    w_state_nxt = S_GAP;
                end else if (w_consumed) begin
                    w_pop          = 1'b1;
                    w_upd_pend_nxt = w_head[23];
                    w_state_nxt    = S_GAP;
                end else if (w_rty) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_UPD: begin
                if (w_timeout || w_rty) begin
                    w_state_nxt = S_GAP;
                end else if (w_consumed) begin
                    w_upd_pend_nxt = 1'b0;
                    w_state_nxt    = S_GAP;
                end
            end
            // GAP folds the IDLE decision in so back-to-back writes cost one idle cycle
            S_GAP: begin
                if (r_upd_pend)          w_state_nxt = S_UPD;
                else if (w_count != '0)  w_state_nxt = S_WR;
                else                     w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_timeout) w_upd_pend_nxt = 1'b0;
    end

    assign w_wr_nxt    = r_wr_ptr + {{c_AW{1'b0}}, w_push};
    assign w_rd_nxt    = w_timeout ? r_wr_ptr : (r_rd_ptr + {{c_AW{1'b0}}, w_pop});
    assign w_count_nxt = w_wr_nxt - w_rd_nxt;

    always_ff @(posedge wb_clk_i) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= {cmd_last_i, cmd_adr_i[6:2], cmd_dat_i};
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_upd_pend  <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_sel_o <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_nxt;
            r_rd_ptr    <= w_rd_nxt;
            r_upd_pend  <= w_upd_pend_nxt;
            cmd_ready_o <= (w_count_nxt != c_FULL);
            busy_o      <= (w_count_nxt != '0) || (w_state_nxt != S_IDLE);
            done_o      <= (r_state == S_UPD) && w_consumed;
            if (w_err || w_timeout) err_o <= 1'b1;
            else if (clr_i)         err_o <= 1'b0;

            // Bus fields load only on strobe entry so they hold while stb is high
            if (w_state_nxt == S_WR && r_state != S_WR) begin
                wb.wb_cyc_o <= 1'b1;
                wb.wb_stb_o <= 1'b1;
                wb.wb_we_o  <= 1'b1;
                wb.wb_adr_o <= {w_head[22:18], 2'b00};
                wb.wb_dat_o <= {{14{w_head[17]}}, w_head[17:0]};
                wb.wb_sel_o <= 4'hF;
            end else if (w_state_nxt == S_UPD && r_state != S_UPD) begin
                wb.wb_cyc_o <= 1'b1;
                wb.wb_stb_o <= 1'b1;
                wb.wb_we_o  <= 1'b1;
                wb.wb_adr_o <= 7'h00;
                wb.wb_dat_o <= 32'h0000_0001;
                wb.wb_sel_o <= 4'h1;
            end else if (w_state_nxt != S_WR && w_state_nxt != S_UPD) begin
                wb.wb_cyc_o <= 1'b0;
                wb.wb_stb_o <= 1'b0;
                wb.wb_we_o  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_biquad8_coeff_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_biquad8_coeff_loader
// Brief    : Scoreboard bench for the biquad8 coefficient loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_biquad8_coeff_loader;

    typedef struct {
        logic [6:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [6:0]  cmd_adr = '0;
    logic [17:0] cmd_dat = '0;
    logic        cmd_last = 1'b0;
    logic        clr = 1'b0;
    logic        cmd_ready, busy, done, err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   kq[$];
    int   gap_q[$];
    int   resp_delay = 3;
    bit   stall = 1'b0;
    int   ack_cnt = 0;
    int   writes = 0;
    int   done_cnt = 0;
    int   last_len = 0;

    always #5 clk = ~clk;

    biquad8_coeff_loader_if wb ();

    biquad8_coeff_loader #(.FIFO_DEPTH(16), .TIMEOUT(64)) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_last_i  (cmd_last),
        .clr_i       (clr),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .wb          (wb)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endfunction

    // Responder: kind 0 ack, 1 err, 2 rty, 3 silent
    initial begin : responder
        int  kind;
        int  wcnt;
        bit  in_txn;
        kind = 0; wcnt = 0; in_txn = 1'b0;
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0; wb.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
            if (!rst_n) begin
                in_txn = 1'b0;
            end else if (wb.wb_cyc_o && wb.wb_stb_o) begin
                if (!in_txn) begin
                    in_txn = 1'b1;
                    wcnt   = 0;
                    kind   = (kq.size() != 0) ? kq.pop_front() : 0;
                end else begin
                    wcnt++;
                end
                if (!stall && kind != 3 && wcnt >= resp_delay - 1) begin
                    case (kind)
                        1:       wb.wb_err_i = 1'b1;
                        2:       wb.wb_rty_i = 1'b1;
                        default: wb.wb_ack_i = 1'b1;
                    endcase
                    ack_cnt++;
                    in_txn = 1'b0;
                end
            end else begin
                in_txn = 1'b0;
            end
        end
    end

    initial begin : monitor
        bit   prev_stb;
        bit   prev_done;
        int   idle_cnt;
        int   cur_len;
        exp_t e;
        exp_t cur;
        prev_stb = 1'b0; prev_done = 1'b0; idle_cnt = 99; cur_len = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stb = 1'b0; prev_done = 1'b0; idle_cnt = 99; cur_len = 0;
            end else begin
                if (wb.wb_cyc_o && wb.wb_stb_o) begin
                    if (!prev_stb) begin
                        writes++;
                        gap_q.push_back(idle_cnt);
                        cur_len = 1;
                        chk("idle_gap_min1", 32'(idle_cnt >= 1), 1);
                        cur.adr = wb.wb_adr_o; cur.dat = wb.wb_dat_o; cur.sel = wb.wb_sel_o;
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write",
                                     wb.wb_adr_o, wb.wb_dat_o);
                        end else begin
                            e = exp_q.pop_front();
                            chk("wr_adr", 32'(wb.wb_adr_o), 32'(e.adr));
                            chk("wr_dat", wb.wb_dat_o, e.dat);
                            chk("wr_sel", 32'(wb.wb_sel_o), 32'(e.sel));
                            chk("wr_we", 32'(wb.wb_we_o), 1);
                        end
                    end else begin
                        cur_len++;
                        chk("stb_stable", 32'({wb.wb_adr_o, wb.wb_sel_o} == {cur.adr, cur.sel} &&
                                              wb.wb_dat_o == cur.dat), 1);
                    end
                    idle_cnt = 0;
                end else begin
                    if (prev_stb) last_len = cur_len;
                    idle_cnt++;
                end
                prev_stb = wb.wb_cyc_o && wb.wb_stb_o;
                if (done) begin
                    done_cnt++;
                    chk("done_one_cycle", 32'(prev_done), 0);
                end
                prev_done = done;
            end
        end
    end

    task automatic push(input logic [6:0] a, input logic [17:0] d, input bit last,
                        input bit exp_en, input logic [6:0] ea, input logic [31:0] ed);
        bit acc;
        acc = 1'b0;
        @(negedge clk); #1;
        cmd_valid = 1'b1; cmd_adr = a; cmd_dat = d; cmd_last = last;
        for (int i = 0; i < 300 && !acc; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                acc = 1'b1;
                if (exp_en) begin
                    exp_q.push_back('{ea, ed, 4'hF});
                    if (last) exp_q.push_back('{7'h00, 32'h1, 4'h1});
                end
            end else begin
                @(negedge clk); #1;
            end
        end
        #1;
        cmd_valid = 1'b0; cmd_last = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL push_accept: got no acceptance, expected ready within 300 cycles");
        end
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (exp_q.size() == 0) break;
        end
        if (i == 2000) begin
            checks++; errors++;
            $display("FAIL %s_drain: got %0d writes outstanding, expected 0", name, exp_q.size());
        end
        repeat (6) @(negedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int d0;
        int w0;
        int i;
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cyc", 32'(wb.wb_cyc_o), 0);
        chk("rst_stb", 32'(wb.wb_stb_o), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy_done_err", 32'({busy, done, err}), 0);
        chk("rst_bus", 32'({wb.wb_we_o, wb.wb_adr_o, wb.wb_sel_o}), 0);
        rst_n = 1'b1;

        // Normal set with push-to-stb latency
        resp_delay = 3;
        d0 = done_cnt;
        push(7'h04, 18'h00123, 1'b0, 1'b1, 7'h04, 32'h0000_0123);
        @(negedge clk); #1;
        chk("latency_n1_stb_low", 32'(wb.wb_stb_o), 0);
        @(negedge clk); #1;
        chk("latency_n2_stb_high", 32'(wb.wb_stb_o), 1);
        push(7'h04, 18'h3FFFF, 1'b0, 1'b1, 7'h04, 32'hFFFF_FFFF);
        push(7'h08, 18'h20000, 1'b1, 1'b1, 7'h08, 32'hFFFE_0000);
        drain("normal");
        chk("normal_done_count", 32'(done_cnt - d0), 1);
        chk("normal_busy_low", 32'(busy), 0);
        chk("normal_err_low", 32'(err), 0);

        // Address masking
        d0 = done_cnt;
        push(7'h17, 18'h00ABC, 1'b1, 1'b1, 7'h14, 32'h0000_0ABC);
        drain("mask");
        chk("mask_done_count", 32'(done_cnt - d0), 1);

        // Backpressure
        resp_delay = 1;
        stall = 1'b1;
        for (int k = 0; k < 16; k++)
            push(7'(k * 4), 18'(k), 1'b0, 1'b1, 7'(k * 4), 32'(k));
        @(negedge clk); #1;
        chk("bp_ready_low_full", 32'(cmd_ready), 0);
        cmd_valid = 1'b1; cmd_adr = 7'h40; cmd_dat = 18'd16; cmd_last = 1'b0;
        w0 = ack_cnt;
        stall = 1'b0;
        for (i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (ack_cnt != w0) break;
        end
        chk("bp_ack_seen", 32'(ack_cnt != w0), 1);
        chk("bp_ready_low_at_ack", 32'(cmd_ready), 0);
        @(negedge clk); #1;
        chk("bp_ready_high_after_ack", 32'(cmd_ready), 1);
        @(posedge clk);
        exp_q.push_back('{7'h40, 32'd16, 4'hF});
        #1;
        cmd_valid = 1'b0;
        drain("bp");

        // err on first of two entries
        resp_delay = 2;
        kq.push_back(1);
        d0 = done_cnt;
        push(7'h10, 18'h00005, 1'b0, 1'b1, 7'h10, 32'h0000_0005);
        push(7'h14, 18'h1FFFF, 1'b1, 1'b1, 7'h14, 32'h0001_FFFF);
        drain("err");
        chk("err_sticky", 32'(err), 1);
        chk("err_done_count", 32'(done_cnt - d0), 1);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0; #1;
        chk("clr_err", 32'(err), 0);

        // rty once: reissue after exactly one idle cycle
        kq.push_back(2);
        gap_q.delete();
        push(7'h18, 18'h00042, 1'b1, 1'b1, 7'h18, 32'h0000_0042);
        exp_q.push_front('{7'h18, 32'h0000_0042, 4'hF});
        drain("rty");
        chk("rty_write_count", 32'(gap_q.size()), 3);
        if (gap_q.size() > 1) chk("rty_reissue_gap", 32'(gap_q[1]), 1);
        chk("rty_err_low", 32'(err), 0);

`ifdef BIQUAD8_LOADER_TIMEOUT_EN
        // Silent target: timeout flushes FIFO and pending update
        kq.push_back(3);
        w0 = writes;
        d0 = done_cnt;
        push(7'h0C, 18'h00007, 1'b0, 1'b1, 7'h0C, 32'h0000_0007);
        push(7'h10, 18'h00008, 1'b1, 1'b0, 7'h10, 32'h0000_0008);
        for (i = 0; i < 300; i++) begin
            @(negedge clk); #1;
            if (!wb.wb_stb_o) break;
        end
        repeat (6) @(negedge clk);
        #1;
        chk("tmo_stb_len", 32'(last_len), 64);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_busy_low", 32'(busy), 0);
        chk("tmo_one_write", 32'(writes - w0), 1);
        chk("tmo_no_done", 32'(done_cnt - d0), 0);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
`endif

        // Asynchronous reset in the middle of a set
        resp_delay = 10;
        push(7'h20, 18'h00001, 1'b0, 1'b1, 7'h20, 32'h0000_0001);
        push(7'h24, 18'h00002, 1'b0, 1'b1, 7'h24, 32'h0000_0002);
        push(7'h28, 18'h00003, 1'b1, 1'b1, 7'h28, 32'h0000_0003);
        for (i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (wb.wb_stb_o) break;
        end
        chk("arst_stb_before", 32'(wb.wb_stb_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cyc_stb", 32'({wb.wb_cyc_o, wb.wb_stb_o}), 0);
        chk("arst_bus", 32'({wb.wb_we_o, wb.wb_adr_o, wb.wb_sel_o}), 0);
        chk("arst_dat", wb.wb_dat_o, 0);
        chk("arst_ready", 32'(cmd_ready), 1);
        chk("arst_busy", 32'(busy), 0);
        exp_q.delete();
        kq.delete();
        w0 = writes;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        chk("arst_no_write_after", 32'(writes - w0), 0);
        chk("arst_idle_busy", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/biquad8_coeff_loader.md
# biquad8_coeff_loader

WISHBONE initiator that programs one biquad8 filter's 7-bit, 32-register coefficient space from a queue of coefficient writes. Upstream logic (a sequencer or a control-bus bridge) pushes address/coefficient pairs into an internal FIFO. The loader issues each pair as a single WISHBONE write, then issues the update strobe (address 0x00, bit 0) after the last entry of a set. It runs in the WISHBONE clock domain of the biquad8 control port and plays the initiator role to that port's target.

## Interface
Parameters:
- FIFO_DEPTH, 16 — command FIFO entries; must be a power of 2, minimum 2.
- TIMEOUT, 255 — maximum cycles to wait for ack/err/rty (timeout build only); range 1 to 65535.

Ports:
- wb_clk_i  in  1  — WISHBONE clock; the only clock.
- wb_rst_ni  in  1  — asynchronous, active-low reset.
- cmd_valid_i  in  1  — command valid.
- cmd_ready_o  out  1  — command accepted when valid && ready. Equals !full.
- cmd_adr_i  in  7  — target register byte address; bits [1:0] are ignored.
- cmd_dat_i  in  18  — signed coefficient.
- cmd_last_i  in  1  — last entry of a set; triggers the update write after it.
- clr_i  in  1  — clears err_o.
- busy_o  out  1  — FIFO not empty, or state is not IDLE.
- done_o  out  1  — one-cycle pulse when the update write completes.
- err_o  out  1  — sticky error flag.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each — initiator strobes.
- wb_adr_o  out  7 — write address.
- wb_dat_o  out  32 — write data.
- wb_sel_o  out  4 — byte selects.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each — target responses.
- wb_dat_i  in  32 — read data; unused, because the loader performs no reads.

## Operation
- FIFO entry fields: {last, adr[6:2], dat[17:0]}.
  - A push occurs when cmd_valid_i && cmd_ready_o.
  - A pop occurs on a completed coefficient write.
- Coefficient write fields:
  - wb_adr_o = {adr[6:2], 2'b00}
  - wb_dat_o = the 18-bit coefficient sign-extended to 32 bits
  - wb_sel_o = 4'hF
  - wb_we_o = 1
- Update write fields: wb_adr_o = 7'h00, wb_dat_o = 32'h1, wb_sel_o = 4'h1.
- State machine:
  - IDLE: go to WR when the FIFO is not empty.
  - WR: drive cyc, stb and we until a response arrives.
    - On ack or err: pop the entry. Go to UPD if the entry's last bit is set, otherwise go to GAP.
    - On rty: do not pop; go to GAP, so the same entry is reissued.
  - UPD: enter through one GAP cycle first, then drive the update write until a response arrives.
    - On ack or err: pulse done_o and go to GAP.
    - On rty: reissue the update write through GAP.
  - GAP: cyc and stb low for exactly 1 cycle, then return to IDLE, or to UPD when an update write is pending.
- The GAP cycle is mandatory. The biquad8 target re-arms its pending flag if stb stays high after an ack, which would duplicate the write.
- A response is any of wb_ack_i, wb_err_i or wb_rty_i sampled high while cyc and stb are high. Priority on simultaneous assertion is err > rty > ack.
- wb_err_i sets err_o. A write that receives err counts as consumed.
- err_o stays set until clr_i. If clr_i and an error event occur in the same cycle, err_o is set (the set wins).
- Pushes remain accepted during any state. A push and a pop in the same cycle while full cannot happen, because ready is low when full. A push and a pop in the same cycle otherwise leave the count unchanged.

## Timing
- All outputs are registered.
- Reset values: every WISHBONE output is 0, cmd_ready_o = 1, busy_o = done_o = err_o = 0, FIFO empty, state IDLE.
- Reset is asynchronous mid-transaction. cyc and stb drop immediately, and pending entries are discarded.
- Latency:
  - A push into an empty FIFO in cycle n makes wb_stb_o high at cycle n+2.
  - An ack sampled at edge k makes cyc and stb low during cycle k+1 (the GAP cycle).
  - The next stb is no earlier than cycle k+2.
- Minimum cost of one coefficient write: ack latency L + 2 cycles.
- done_o is high the cycle after the update write's ack is sampled.
- wb_adr_o, wb_dat_o and wb_sel_o are stable for the whole time stb is high.

## Configuration
- Macro: BIQUAD8_LOADER_TIMEOUT_EN.
- With the macro defined:
  - A counter starts at stb assertion.
  - If TIMEOUT cycles pass with no response, cyc and stb drop at the next edge and err_o is set.
  - The whole FIFO is flushed, including any pending update write, and the state returns to IDLE through GAP.
- Without the macro: no counter exists, and the loader waits for a response indefinitely.

## Test plan
- Normal set: push (0x04, 0x00123), (0x04, 0x3FFFF), (0x08 last, 0x20000); the responder acks 3 cycles after stb. Expect:
  - Writes of 0x00000123 @0x04, 0xFFFFFFFF @0x04 and 0xFFFE0000 @0x08.
  - Then the update write 0x00000001 @0x00 with sel 0x1.
  - One done_o pulse, at least 1 idle cycle between transactions, and busy_o low afterwards.
- Backpressure: stall the responder and push 17 non-last entries with FIFO_DEPTH = 16. Expect cmd_ready_o low after 16 accepted pushes; it returns high one cycle after the first ack.
- Address masking: push cmd_adr_i = 0x17. Expect wb_adr_o = 0x14.
- Errors:
  - err on the 1st of 2 entries: err_o = 1 and the 2nd entry is still written.
  - rty once: the same address and data are reissued after exactly 1 idle cycle.
  - clr_i pulse: err_o = 0.
- Timeout (build with the macro, TIMEOUT = 64): the responder never answers. Expect stb to drop 64 cycles after rising, err_o = 1, FIFO empty, and no update write.
- Reset: assert wb_rst_ni low during stb of a 3-entry set. Expect all outputs at reset values asynchronously, and no write issued after release.
